// File: rtl/mux_8_way_pkg.sv
// Shared constants and types for the 8-way round-robin output mux.
package mux_8_way_pkg;
  localparam int NUM_CH    = 8;
  localparam int SEL_W     = 3;
  localparam int DEF_WIDTH = 16;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_arbiter_8.sv
// Rotating-priority encoder: one-hot grant of the first requester at or above ptr, wrapping 7->0.
// Latency: combinational. Backpressure: none, the caller qualifies the grant.
module rr_arbiter_8
  import mux_8_way_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [7:0] grant
);

  sel_t idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    // 3-bit addition wraps the search around channel 7 back to channel 0
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr + sel_t'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_8_way_rr.sv
// 8-channel round-robin mux into a one-word output register; MUX_8_WAY_RR_STALL_CNT_EN adds stall_cnt.
// Latency: one cycle from accept to out_valid. Backpressure: in_ready drops when the register is full and out_ready is low.
module mux_8_way_rr
  import mux_8_way_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
`ifdef MUX_8_WAY_RR_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state;
  sel_t       ptr;
  logic [7:0] grant;
  sel_t       gnt_idx;
  logic       load;

  assign out_valid = (state == FULL);
  assign load      = !out_valid || out_ready;

  rr_arbiter_8 u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) gnt_idx = sel_t'(k);
    end
  end

  // Reset gates the handshake so nothing is consumed while the output is being cleared
  assign in_ready = reset ? 8'h00 : (grant & {NUM_CH{load}});

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
`ifdef MUX_8_WAY_RR_STALL_CNT_EN
      stall_cnt <= '0;
`endif
    end else begin
      if (load) begin
        if (|grant) begin
          state    <= FULL;
          out_data <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
          out_sel  <= gnt_idx;
          ptr      <= gnt_idx + sel_t'(1);
        end else begin
          state <= EMPTY;
        end
      end
`ifdef MUX_8_WAY_RR_STALL_CNT_EN
      if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mux_8_way_rr.sv
// Scoreboard bench for mux_8_way_rr: directed scenarios plus random traffic against a queue-based reference model.
module tb_mux_8_way_rr;
  import mux_8_way_pkg::*;

  localparam int W = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic [7:0]     in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready;
`ifdef MUX_8_WAY_RR_STALL_CNT_EN
  logic [15:0]    stall_cnt;
`endif

  mux_8_way_rr #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef MUX_8_WAY_RR_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] d;
    int           s;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] ch_data[8];
  int           errors = 0;
  int           checks = 0;

  // Reference state: is a word held, where the next search starts, stall cycles seen
  bit m_valid;
  int m_ptr;
  int m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [7:0] v, input logic rdy);
    int         win;
    bit         load;
    logic [7:0] exp_rdy;
    @(posedge clock);
    #1;
    in_valid  = v;
    out_ready = rdy;
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = ch_data[i];
    #1;
    load = !m_valid || rdy;
    win  = -1;
    for (int k = 0; k < 8; k++) begin
      if (win < 0 && v[(m_ptr + k) % 8]) win = (m_ptr + k) % 8;
    end
    exp_rdy = (load && win >= 0) ? (8'b1 << win) : 8'h00;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("in_ready", {24'd0, in_ready}, {24'd0, exp_rdy});
    chk("in_ready_onehot0", {31'd0, $onehot0(in_ready)}, 32'd1);
    if (out_valid && !out_ready) chk("in_ready_stalled", {24'd0, in_ready}, 32'd0);
`ifdef MUX_8_WAY_RR_STALL_CNT_EN
    chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
    if (m_valid && !rdy && m_stall < 65535) m_stall++;
    if (load) begin
      if (win >= 0) begin
        sb.push_back('{d: ch_data[win], s: win});
        m_valid = 1'b1;
        m_ptr   = (win + 1) % 8;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("in_ready_in_reset", {24'd0, in_ready}, 32'd0);
    @(posedge clock);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sel", {29'd0, out_sel}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_in_ready", {24'd0, in_ready}, 32'd0);
`ifdef MUX_8_WAY_RR_STALL_CNT_EN
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    reset     = 1'b0;
    in_valid  = 8'h00;
    out_ready = 1'b1;
    sb.delete();
    m_valid = 1'b0;
    m_ptr   = 0;
    m_stall = 0;
  endtask

  // Monitor: the head of the queue is the word that should sit in the output register
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual sel=%0d data=%0h required no word", out_sel, out_data);
        end else begin
          chk("out_data", {16'd0, out_data}, {16'd0, sb[0].d});
          chk("out_sel", {29'd0, out_sel}, sb[0].s);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 8'h00;
    in_data   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) ch_data[i] = W'(16'h0100 + i);
    do_reset();

    // Single requester on channel 2, then ptr=3 shows in the next grant
    ch_data[2] = 16'h00AA;
    step(8'b0000_0100, 1'b1);
    ch_data[2] = 16'h0102;
    step(8'hFF, 1'b1);
    step(8'h00, 1'b1);

    // All channels valid: back-to-back rotation 0..7,0
    do_reset();
    for (int n = 0; n < 9; n++) step(8'hFF, 1'b1);

    // Hold channel 5's word for three stalled cycles
    do_reset();
    step(8'b0010_0000, 1'b1);
    for (int n = 0; n < 3; n++) step(8'hFF, 1'b0);
    step(8'hFF, 1'b1);
    step(8'h00, 1'b1);

    // Wrap from ptr=6 down to channel 0, then channel 1
    do_reset();
    step(8'b0010_0000, 1'b1);
    step(8'b0000_0011, 1'b1);
    step(8'b0000_0011, 1'b1);
    step(8'h00, 1'b1);

    // Reset while full with every channel requesting
    for (int n = 0; n < 3; n++) step(8'hFF, 1'b1);
    in_valid = 8'hFF;
    do_reset();
    step(8'hFF, 1'b1);
    step(8'h00, 1'b1);

    // Random traffic with random backpressure and sparse or dense requests
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] v;
      for (int i = 0; i < 8; i++) ch_data[i] = W'($urandom);
      v = 8'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & 8'($urandom);
      step(v, $urandom_range(0, 9) < 7);
    end
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    chk("queue_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_8_way_rr.md
MUX_8_WAY_RR -- requirements
Module: mux_8_way_rr

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width of every channel (Hack word).
REQ-002 Port clock, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1: reset SHALL be synchronous and active-high.
REQ-004 Port in_valid, input, 8: per-channel request, bit i = channel i.
REQ-005 Port in_data, input, 8*WIDTH: channel i data in bits [i*WIDTH +: WIDTH].
REQ-006 Port in_ready, output, 8: bit i high means channel i's word is taken this cycle.
REQ-007 Port out_valid, output, 1: output register holds a word.
REQ-008 Port out_data, output, WIDTH: registered winning word.
REQ-009 Port out_sel, output, 3: index of the channel out_data came from.
REQ-010 Port out_ready, input, 1: downstream accepts when out_valid && out_ready.

Function
REQ-011 Two states SHALL exist: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-012 load = !out_valid || out_ready; a transfer from channel i SHALL occur iff load && grant[i].
REQ-013 grant SHALL be one-hot or zero; it selects the first channel with in_valid set, searching upward from ptr and wrapping 7->0.
REQ-014 in_ready SHALL equal grant & {8{load}} (combinational; at most one bit high).
REQ-015 On a transfer from channel i: out_data<=in_data[i], out_sel<=i, out_valid<=1, ptr<=(i+1) mod 8.
REQ-016 If load and no in_valid bit is set: out_valid<=0, ptr unchanged, out_data/out_sel hold.
REQ-017 If !load (FULL and out_ready=0): out_data, out_sel, out_valid and ptr SHALL hold; in_ready=0.
REQ-018 Output drained and refilled in the same cycle (FULL, out_ready=1, some in_valid) SHALL sustain one word per cycle with no bubble.
REQ-019 Latency SHALL be one cycle from the transfer edge to out_valid.
REQ-020 With all 8 channels continuously valid and out_ready=1, grants SHALL rotate 0..7 with no channel granted twice in 8 cycles.
REQ-021 in_valid/in_data SHALL NOT be required to hold once dropped; no combinational path from out_ready to out_data.

Reset
REQ-022 On reset: out_valid=0, out_data=0, out_sel=0, ptr=0, stall counter (if built) =0.
REQ-023 Reset mid-operation SHALL discard any held word; in_ready SHALL be 0 while reset is high.

Configuration
REQ-024 Macro MUX_8_WAY_RR_STALL_CNT_EN defined: extra output port stall_cnt, 16 bits, counts cycles with out_valid && !out_ready, saturating at 16'hFFFF.
REQ-025 Macro undefined: port stall_cnt and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-026 Package mux_8_way_pkg SHALL hold NUM_CH=8, SEL_W=3, the default WIDTH, and typedef sel_t.
REQ-027 The rotating priority encoder SHALL be sub-module rr_arbiter_8 (inputs req[7:0], ptr[2:0]; output grant[7:0]), purely combinational; all state stays in mux_8_way_rr.

Verification
REQ-028 Reset, then in_valid=8'b0000_0100, in_data ch2=16'h00AA, out_ready=1 -> in_ready=8'b0000_0100; next cycle out_valid=1, out_data=16'h00AA, out_sel=2; ptr=3.
REQ-029 in_valid=8'hFF held, channel i data=16'h0100+i, out_ready=1 -> out_sel sequence 0,1,...,7,0 on consecutive cycles, no gaps.
REQ-030 FULL with out_sel=5, out_ready=0 for 3 cycles, in_valid=8'hFF -> in_ready=0, outputs frozen; stall_cnt=3 when macro defined.
REQ-031 ptr=6, in_valid=8'b0000_0011 -> grant channel 0 (wrap), then channel 1 next cycle.
REQ-032 Assert reset while FULL and in_valid=8'hFF -> next cycle out_valid=0, out_sel=0, in_ready=0; after release first grant is channel 0.
REQ-033 Check every cycle: in_ready one-hot or zero, and in_ready=0 whenever out_valid && !out_ready.
